// File: rtl/mdu_pkg.sv
// mdu_pkg -- shared definitions for the HI/LO multiply/divide controller.
//   * req_op encodings (MULT, MULTU, DIV, DIVU, MTHI, MTLO; others are no-ops)
//   * FSM state encoding
//   * default multiplier latency
package mdu_pkg;

  localparam int MUL_LAT_DEFAULT = 2;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  // state       | meaning
  // ST_IDLE     | no operation held; MTHI/MTLO complete here in one cycle
  // ST_MUL_WAIT | waiting MUL_LAT cycles for the fixed-latency multiplier
  // ST_DIV_WAIT | divider running; waiting for div_ready
  // ST_DONE     | single write-back cycle of HI/LO
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MUL_WAIT = 2'd1,
    ST_DIV_WAIT = 2'd2,
    ST_DONE     = 2'd3
  } mdu_state_e;

endpackage

// File: rtl/mdu_ctrl.sv
// mdu_ctrl -- HI/LO multiply/divide sequencing controller.
//
// Accepts an EX-stage HI/LO operation, holds the pipeline (stall_req) while
// the external multiplier or divider works, then writes HI/LO back in a
// single DONE cycle. MTHI/MTLO complete combinationally while idle.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   req_valid, req_op             operation request and opcode
//   src_a, src_b                  operands (rs, rt)
//   flush                         abort any in-flight operation
//   mul_signed, mul_a, mul_b      multiplier operands (0 when unused)
//   mul_result                    multiplier product, valid MUL_LAT cycles later
//   div_start/div_signed/div_annul, div_a, div_b   divider control/operands
//   div_ready, div_result         divider completion and {remainder,quotient}
//   stall_req, busy               pipeline hold, FSM not idle
//   hi_we/lo_we, hi_wdata/lo_wdata, done   HI/LO write-back
//
// Parameter MUL_LAT: multiplier latency in cycles, 1..7.
// Build option MDU_DIV0_GUARD_EN: when defined, DIV/DIVU by zero bypass the
// divider and complete one cycle after acceptance with HI=src_a, LO=all ones.
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int MUL_LAT = MUL_LAT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic [2:0]  req_op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        flush,
  output logic        mul_signed,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  input  logic [63:0] mul_result,
  output logic        div_start,
  output logic        div_signed,
  output logic        div_annul,
  output logic [31:0] div_a,
  output logic [31:0] div_b,
  input  logic        div_ready,
  input  logic [63:0] div_result,
  output logic        stall_req,
  output logic        busy,
  output logic        hi_we,
  output logic        lo_we,
  output logic [31:0] hi_wdata,
  output logic [31:0] lo_wdata,
  output logic        done
);

  localparam logic [2:0] CNT_INIT = 3'(MUL_LAT - 1);

  mdu_state_e  state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] opa_q, opa_d;
  logic [31:0] opb_q, opb_d;
  logic        sgn_q, sgn_d;
  logic [63:0] res_q, res_d;
  logic        div0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      sgn_q   <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      sgn_q   <= sgn_d;
      res_q   <= res_d;
    end
  end

  // Operation class (multiply vs divide) is carried by the wait state itself.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    opa_d      = opa_q;
    opb_d      = opb_q;
    sgn_d      = sgn_q;
    res_d      = res_q;
    mul_signed = 1'b0;
    mul_a      = '0;
    mul_b      = '0;
    div_start  = 1'b0;
    div_signed = 1'b0;
    div_annul  = 1'b0;
    div_a      = '0;
    div_b      = '0;
    stall_req  = 1'b0;
    busy       = 1'b0;
    hi_we      = 1'b0;
    lo_we      = 1'b0;
    hi_wdata   = '0;
    lo_wdata   = '0;
    done       = 1'b0;
    div0       = 1'b0;
`ifdef MDU_DIV0_GUARD_EN
    div0       = (src_b == 32'd0);
`endif

    // Outputs are forced to zero while rst is high; the register block
    // ignores the next-state values during reset.
    if (!rst) begin
      busy = (state_q != ST_IDLE);
      case (state_q)
        ST_IDLE: begin
          if (req_valid && !flush) begin
            case (req_op)
              OP_MULT, OP_MULTU: begin
                stall_req  = 1'b1;
                mul_signed = (req_op == OP_MULT);
                mul_a      = src_a;
                mul_b      = src_b;
                opa_d      = src_a;
                opb_d      = src_b;
                sgn_d      = (req_op == OP_MULT);
                cnt_d      = CNT_INIT;
                state_d    = ST_MUL_WAIT;
              end
              OP_DIV, OP_DIVU: begin
                stall_req = 1'b1;
                opa_d     = src_a;
                opb_d     = src_b;
                sgn_d     = (req_op == OP_DIV);
                if (div0) begin
                  res_d   = {src_a, 32'hFFFF_FFFF};
                  state_d = ST_DONE;
                end else begin
                  div_start  = 1'b1;
                  div_signed = (req_op == OP_DIV);
                  div_a      = src_a;
                  div_b      = src_b;
                  state_d    = ST_DIV_WAIT;
                end
              end
              OP_MTHI: begin
                hi_we    = 1'b1;
                hi_wdata = src_a;
                done     = 1'b1;
              end
              OP_MTLO: begin
                lo_we    = 1'b1;
                lo_wdata = src_a;
                done     = 1'b1;
              end
              default: ;
            endcase
          end
        end

        ST_MUL_WAIT: begin
          stall_req  = 1'b1;
          mul_signed = sgn_q;
          mul_a      = opa_q;
          mul_b      = opb_q;
          if (flush) begin
            cnt_d   = '0;
            state_d = ST_IDLE;
          end else if (cnt_q == 3'd0) begin
            res_d   = mul_result;
            state_d = ST_DONE;
          end else begin
            cnt_d = cnt_q - 3'd1;
          end
        end

        ST_DIV_WAIT: begin
          stall_req  = 1'b1;
          div_start  = !div_ready;
          div_signed = sgn_q;
          div_a      = opa_q;
          div_b      = opb_q;
          if (flush) begin
            div_annul = 1'b1;
            state_d   = ST_IDLE;
          end else if (div_ready) begin
            res_d   = div_result;
            state_d = ST_DONE;
          end
        end

        ST_DONE: begin
          // A flush landing on the write-back cycle cancels the write.
          if (!flush) begin
            hi_we    = 1'b1;
            lo_we    = 1'b1;
            hi_wdata = res_q[63:32];
            lo_wdata = res_q[31:0];
            done     = 1'b1;
          end
          state_d = ST_IDLE;
        end

        default: state_d = ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl -- scoreboard bench for mdu_ctrl with behavioural multiplier
// and divider models. Honours MDU_DIV0_GUARD_EN when compiled with it.
module tb_mdu_ctrl;
  import mdu_pkg::*;

  localparam int MUL_LAT = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic [2:0]  req_op = 3'b000;
  logic [31:0] src_a = '0;
  logic [31:0] src_b = '0;
  logic        flush = 1'b0;
  logic        mul_signed;
  logic [31:0] mul_a, mul_b;
  logic [63:0] mul_result;
  logic        div_start, div_signed, div_annul;
  logic [31:0] div_a, div_b;
  logic        div_ready;
  logic [63:0] div_result;
  logic        stall_req, busy, hi_we, lo_we, done;
  logic [31:0] hi_wdata, lo_wdata;

  always #5 clk = ~clk;

  mdu_ctrl #(.MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_op(req_op),
    .src_a(src_a), .src_b(src_b), .flush(flush),
    .mul_signed(mul_signed), .mul_a(mul_a), .mul_b(mul_b), .mul_result(mul_result),
    .div_start(div_start), .div_signed(div_signed), .div_annul(div_annul),
    .div_a(div_a), .div_b(div_b), .div_ready(div_ready), .div_result(div_result),
    .stall_req(stall_req), .busy(busy), .hi_we(hi_we), .lo_we(lo_we),
    .hi_wdata(hi_wdata), .lo_wdata(lo_wdata), .done(done)
  );

  int n_checks = 0;
  int n_errors = 0;

  function automatic void check(string name, logic [127:0] act, logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference arithmetic straight from the instruction definitions.
  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b, input logic s);
    longint p;
    logic [63:0] u;
    if (s) begin
      p = longint'($signed(a)) * longint'($signed(b));
      return 64'(p);
    end
    u = {32'b0, a} * {32'b0, b};
    return u;
  endfunction

  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic s);
    longint sa, sb, q, r;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'b0, a});
      sb = longint'({32'b0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  // Multiplier: pure MUL_LAT-stage pipeline.
  logic [63:0] mul_pipe [MUL_LAT];
  always @(posedge clk) begin
    mul_pipe[0] <= ref_mul(mul_a, mul_b, mul_signed);
    for (int i = 1; i < MUL_LAT; i++) mul_pipe[i] <= mul_pipe[i-1];
  end
  assign mul_result = mul_pipe[MUL_LAT-1];

  // Divider: starts on div_start, raises div_ready div_lat cycles after busy.
  int          div_lat = 1;
  logic        dv_busy = 1'b0;
  int          dv_cnt = 0;
  logic [63:0] dv_res = '0;
  assign div_ready  = dv_busy && (dv_cnt == 0);
  assign div_result = div_ready ? dv_res : 64'd0;
  always @(posedge clk) begin
    if (rst || div_annul) dv_busy <= 1'b0;
    else if (!dv_busy && div_start) begin
      dv_busy <= 1'b1;
      dv_cnt  <= div_lat;
      dv_res  <= ref_div(div_a, div_b, div_signed);
    end else if (dv_busy) begin
      if (dv_cnt == 0) dv_busy <= 1'b0;
      else dv_cnt <= dv_cnt - 1;
    end
  end

  typedef struct packed {
    logic        hwe;
    logic        lwe;
    logic [31:0] hi;
    logic [31:0] lo;
  } wb_t;
  wb_t sb[$];

  // Monitor: every write-back must match the oldest expected one.
  always @(negedge clk) begin
    if (!rst && (hi_we || lo_we || done)) begin
      if (sb.size() == 0) check("unexpected_wb", {hi_we, lo_we, done}, 3'b000);
      else begin
        wb_t e;
        e = sb.pop_front();
        check("wb_done", done, 1'b1);
        check("wb", {hi_we, lo_we, hi_wdata, lo_wdata}, e);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input int lat);
    wb_t e;
    int  exp_done, c, done_at, stall_n, start_n;
    bit  is_mul, is_div, g0, got;
    is_mul = (op == OP_MULT) || (op == OP_MULTU);
    is_div = (op == OP_DIV) || (op == OP_DIVU);
    g0 = 1'b0;
`ifdef MDU_DIV0_GUARD_EN
    g0 = is_div && (b == 32'd0);
`endif
    exp_done = -1;
    if (is_mul) begin
      e = {2'b11, ref_mul(a, b, op == OP_MULT)};
      exp_done = MUL_LAT + 1;
    end else if (is_div) begin
      e = {2'b11, ref_div(a, b, op == OP_DIV)};
      exp_done = g0 ? 1 : lat + 2;
    end else if (op == OP_MTHI) begin
      e = {2'b10, a, 32'd0};
      exp_done = 0;
    end else if (op == OP_MTLO) begin
      e = {2'b01, 32'd0, a};
      exp_done = 0;
    end
    if (exp_done >= 0) sb.push_back(e);
    req_valid = 1'b1; req_op = op; src_a = a; src_b = b; div_lat = lat;
    if (exp_done < 0) begin
      @(negedge clk);
      check("noop_quiet", {stall_req, busy, done}, 3'b000);
      step();
      req_valid = 1'b0;
      return;
    end
    c = 0; got = 1'b0; done_at = -1; stall_n = 0; start_n = 0;
    while (!got && c < 300) begin
      @(negedge clk);
      if (c == 0 && is_mul) check("mul_ops_T", {mul_signed, mul_a, mul_b}, {op == OP_MULT, a, b});
      if (c == 0 && is_div && !g0) check("div_ops_T", {div_signed, div_a, div_b}, {op == OP_DIV, a, b});
      if (stall_req) stall_n++;
      if (div_start) start_n++;
      if (done) begin got = 1'b1; done_at = c; end
      step();
      c++;
    end
    req_valid = 1'b0;
    check("done_latency", 128'(done_at), 128'(exp_done));
    check("stall_cycles", 128'(stall_n), 128'(exp_done));
    if (is_div) check("div_start_cycles", 128'(start_n), 128'(g0 ? 0 : exp_done - 1));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  op;
    logic [31:0] a, b;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("reset_outputs", |{mul_signed, mul_a, mul_b, div_start, div_signed, div_annul, div_a, div_b,
                             stall_req, busy, hi_we, lo_we, hi_wdata, lo_wdata, done}, 1'b0);
    step();
    rst = 1'b0;
    @(negedge clk);
    check("idle_after_reset", {busy, stall_req}, 2'b00);
    step();

    // Directed cases.
    run_op(OP_MULT, 32'hFFFF_FFFD, 32'd5, 1);
    run_op(OP_DIVU, 32'd100, 32'd7, 32);
    run_op(OP_MTLO, 32'h1234_5678, 32'd0, 1);
    run_op(OP_MTHI, 32'hCAFE_F00D, 32'd9, 1);
    run_op(OP_DIV, 32'hFFFF_FF9C, 32'd7, 3);
    run_op(OP_DIV, 32'h0000_0042, 32'd0, 4);
    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
    run_op(3'b110, 32'd1, 32'd2, 1);

    // Flush in the 10th DIV_WAIT cycle.
    req_valid = 1'b1; req_op = OP_DIV; src_a = 32'd500; src_b = 32'd5; div_lat = 40;
    repeat (10) step();
    flush = 1'b1;
    @(negedge clk);
    check("flush_annul", {div_annul, busy}, 2'b11);
    step();
    flush = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    check("flush_idle", {busy, stall_req, hi_we, lo_we}, 4'b0000);
    step();

    // Flush in IDLE blocks acceptance (and MTHI write).
    req_valid = 1'b1; req_op = OP_MULT; src_a = 32'd3; src_b = 32'd4; flush = 1'b1;
    @(negedge clk);
    check("flush_blocks_accept", {stall_req, done}, 2'b00);
    step();
    req_op = OP_MTHI;
    @(negedge clk);
    check("flush_blocks_mt", {hi_we, done}, 2'b00);
    step();
    flush = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    check("flush_idle_busy", busy, 1'b0);
    step();

    // Reset during MUL_WAIT.
    req_valid = 1'b1; req_op = OP_MULT; src_a = 32'd11; src_b = 32'd13;
    step();
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_outputs", |{mul_signed, mul_a, mul_b, div_start, div_signed, div_annul, div_a, div_b,
                               stall_req, busy, hi_we, lo_we, hi_wdata, lo_wdata, done}, 1'b0);
    step();
    rst = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    check("rst_mid_idle", busy, 1'b0);
    step();
    run_op(OP_MULTU, 32'h8000_0001, 32'd3, 1);

    // Randomized mix.
    for (int i = 0; i < 60; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = ($urandom_range(0, 5) == 0) ? 32'd0 :
           ($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 50)) : $urandom;
      run_op(op, a, b, int'($urandom_range(1, 20)));
      if ($urandom_range(0, 2) == 0) step();
    end

    repeat (3) step();
    check("scoreboard_empty", 128'(sb.size()), 128'(0));
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/mdu_ctrl.md
MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 SHALL have parameter MUL_LAT, default 2, fixed multiplier latency in cycles, legal range 1..7.
REQ-002 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port req_valid  input  1  EX-stage HI/LO operation present.
REQ-005 SHALL have port req_op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, others no-op.
REQ-006 SHALL have ports src_a, src_b  input  32 each  operands (rs, rt).
REQ-007 SHALL have port flush  input  1  abort any in-flight operation.
REQ-008 SHALL have ports mul_signed/mul_a/mul_b  output  1/32/32, and mul_result  input  64  multiplier interface.
REQ-009 SHALL have ports div_start/div_signed/div_annul  output  1 each, div_a/div_b  output  32 each, div_ready  input  1, div_result  input  64 {remainder,quotient}.
REQ-010 SHALL have ports stall_req  output  1  pipeline hold, and busy  output  1  FSM not IDLE.
REQ-011 SHALL have ports hi_we/lo_we  output  1 each, hi_wdata/lo_wdata  output  32 each, done  output  1  HI/LO write-back.

Function
REQ-012 FSM SHALL have states IDLE, MUL_WAIT, DIV_WAIT, DONE; busy = (state != IDLE).
REQ-013 In IDLE with req_valid, flush=0, op MULT/MULTU/DIV/DIVU (acceptance cycle T): SHALL latch src_a, src_b, signed flag, op class, and assert stall_req in T.
REQ-014 MUL: mul_a/mul_b SHALL equal src in T and latched operands in MUL_WAIT; a counter SHALL run MUL_LAT cycles; mul_result SHALL be captured at the end of T+MUL_LAT; DONE in T+MUL_LAT+1.
REQ-015 DIV: div_start SHALL be 1 from T through every DIV_WAIT cycle with div_ready=0, and 0 in the cycle div_ready=1; div_result SHALL be captured in that cycle; DONE next cycle.
REQ-016 stall_req SHALL be 1 in T and in every MUL_WAIT/DIV_WAIT cycle, 0 in DONE and idle cycles.
REQ-017 DONE SHALL last exactly one cycle: hi_we=lo_we=done=1; MUL: hi=result[63:32], lo=result[31:0]; DIV: hi=remainder, lo=quotient; next state IDLE.
REQ-018 DONE SHALL NOT accept req_valid; the held instruction retires at the end of DONE.
REQ-019 MTHI/MTLO in IDLE SHALL complete in the same cycle: hi_we (or lo_we)=1, wdata=src_a, done=1, stall_req=0, state unchanged.
REQ-020 flush SHALL force IDLE at the next edge from any state with no HI/LO write; div_annul=1 in that cycle if in DIV_WAIT; flush wins over simultaneous div_ready or counter expiry; flush in IDLE SHALL block acceptance.
REQ-021 Unused outputs SHALL be 0 (mul/div operands 0 when not in use).

Reset
REQ-022 rst SHALL set state IDLE, counter 0, latched operands and result registers 0; all outputs 0 in the reset cycle, including mid-operation; rst overrides flush.

Configuration
REQ-023 With MDU_DIV0_GUARD_EN defined, DIV/DIVU with src_b==0 at T SHALL bypass the divider (div_start stays 0) and enter DONE at T+1 with hi=src_a, lo=32'hFFFF_FFFF.
REQ-024 Without MDU_DIV0_GUARD_EN, divide-by-zero SHALL be issued to the divider like any other division.

Structure
REQ-025 Package mdu_pkg SHALL hold req_op encodings, FSM state encoding, and the MUL_LAT default constant.
REQ-026 No sub-module SHALL be required; FSM, latency counter and result register are inline.

Verification
REQ-027 MULT src_a=-3, src_b=5, MUL_LAT=2, model result 64'hFFFF_FFFF_FFFF_FFF1 -> stall_req 3 cycles, DONE at T+3, hi=FFFF_FFFF, lo=FFFF_FFF1.
REQ-028 DIVU 100/7, div_ready after 33 cycles -> div_start held until div_ready, DONE next cycle, hi=2, lo=14, stall_req drops in DONE.
REQ-029 MTLO src_a=32'h1234_5678 in IDLE -> lo_we=1, lo_wdata=1234_5678, done=1 same cycle, stall_req=0.
REQ-030 flush in 10th DIV_WAIT cycle -> div_annul pulse, IDLE next edge, no hi_we/lo_we.
REQ-031 DIV src_b=0 with MDU_DIV0_GUARD_EN -> no div_start, DONE at T+1, lo=FFFF_FFFF; without the macro -> normal divider handshake.
REQ-032 rst asserted in MUL_WAIT -> all outputs 0, IDLE; next MULTU accepted normally.
